// File: rtl/issue_scoreboard.sv
// Dual-issue in-order register scoreboard: tracks per-register pending results with
// per-class forwarding countdowns and decides which of two slots may issue each cycle.
module issue_scoreboard #(
  parameter int unsigned LAT_ALU = 1,
  parameter int unsigned LAT_BRU = 1,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_MEM = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            stall_in,
  input  logic [1:0]      in_valid,
  input  logic [1:0][4:0] src1_addr,
  input  logic [1:0][4:0] src2_addr,
  input  logic [1:0]      src1_used,
  input  logic [1:0]      src2_used,
  input  logic [1:0]      dst_wen,
  input  logic [1:0][4:0] dst_addr,
  input  logic [1:0][2:0] exec_class,
  input  logic [1:0]      wb_valid,
  input  logic [1:0][4:0] wb_addr,
  output logic [1:0]      issue_fire,
  output logic [31:0]     stall_cycles
);

  localparam logic [2:0] CntWaitWb = 3'd7;

  // Entry 0 exists only to keep indexing uniform; it is held at zero.
  logic [31:0]      busy_q, busy_d;
  logic [31:0][2:0] cnt_q, cnt_d;
  logic [31:0]      stall_q, stall_d;

  logic [31:0] reg_rdy;
  logic [31:0] div_pend;
  logic [31:0] wb_hit;
  logic [1:0]  src_ok, waw_ok, alloc;
  logic        raw01, waw01;

  function automatic logic [2:0] class_lat(input logic [2:0] c);
    case (c)
      3'd0:    class_lat = 3'(LAT_ALU);
      3'd1:    class_lat = 3'(LAT_BRU);
      3'd2:    class_lat = 3'(LAT_MUL);
      3'd3:    class_lat = 3'(LAT_MEM);
      default: class_lat = CntWaitWb;
    endcase
  endfunction

  // A count of 1 means the result is forwarded into a consumer issuing this cycle.
  always_comb begin
    reg_rdy  = '0;
    div_pend = '0;
    wb_hit   = '0;
    for (int r = 0; r < 32; r++) begin
      wb_hit[r]   = (wb_valid[0] && wb_addr[0] == 5'(r)) || (wb_valid[1] && wb_addr[1] == 5'(r));
      div_pend[r] = (r != 0) && busy_q[r] && (cnt_q[r] == CntWaitWb);
      reg_rdy[r]  = (r == 0) || !busy_q[r] || (cnt_q[r] <= 3'd1) || wb_hit[r];
    end
  end

  always_comb begin
    src_ok = '0;
    waw_ok = '0;
    alloc  = '0;
    for (int i = 0; i < 2; i++) begin
      src_ok[i] = (!src1_used[i] || reg_rdy[src1_addr[i]]) &&
                  (!src2_used[i] || reg_rdy[src2_addr[i]]);
      alloc[i]  = dst_wen[i] && (dst_addr[i] != 5'd0);
      waw_ok[i] = !(alloc[i] && div_pend[dst_addr[i]]);
    end
    raw01 = alloc[0] && ((src1_used[1] && src1_addr[1] == dst_addr[0]) ||
                         (src2_used[1] && src2_addr[1] == dst_addr[0]));
    waw01 = alloc[0] && alloc[1] && (dst_addr[0] == dst_addr[1]);

    issue_fire    = '0;
    issue_fire[0] = resetn && in_valid[0] && !stall_in && !flush && src_ok[0] && waw_ok[0];
    issue_fire[1] = issue_fire[0] && in_valid[1] && src_ok[1] && !raw01 && !waw01 && waw_ok[1];
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int r = 1; r < 32; r++) begin
      if (wb_hit[r]) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = 3'd0;
      end else if (busy_q[r] && cnt_q[r] != 3'd0 && cnt_q[r] != CntWaitWb) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
    // Allocation overrides a same-cycle writeback to the same register.
    for (int i = 0; i < 2; i++) begin
      if (issue_fire[i] && alloc[i]) begin
        busy_d[dst_addr[i]] = 1'b1;
        cnt_d[dst_addr[i]]  = class_lat(exec_class[i]);
      end
    end
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = 3'd0;
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid[0] && !issue_fire[0] && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: each cycle drives one issue group and compares
// issue_fire against a hand-derived value; stall_cycles is tracked by a tiny counter model.
module tb_issue_scoreboard;

  logic            clk = 1'b0;
  logic            resetn, flush, stall_in;
  logic [1:0]      in_valid, src1_used, src2_used, dst_wen, wb_valid;
  logic [1:0][4:0] src1_addr, src2_addr, dst_addr, wb_addr;
  logic [1:0][2:0] exec_class;
  logic [1:0]      issue_fire;
  logic [31:0]     stall_cycles;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_stall;

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .stall_in    (stall_in),
    .in_valid    (in_valid),
    .src1_addr   (src1_addr),
    .src2_addr   (src2_addr),
    .src1_used   (src1_used),
    .src2_used   (src2_used),
    .dst_wen     (dst_wen),
    .dst_addr    (dst_addr),
    .exec_class  (exec_class),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .issue_fire  (issue_fire),
    .stall_cycles(stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid   = '0;
    src1_addr  = '0;
    src2_addr  = '0;
    src1_used  = '0;
    src2_used  = '0;
    dst_wen    = '0;
    dst_addr   = '0;
    exec_class = '0;
    wb_valid   = '0;
    wb_addr    = '0;
    flush      = 1'b0;
    stall_in   = 1'b0;
  endtask

  task automatic slot(input int s, input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                      input logic u2, input logic w, input logic [4:0] d, input logic [2:0] c);
    in_valid[s]   = 1'b1;
    src1_addr[s]  = s1;
    src1_used[s]  = u1;
    src2_addr[s]  = s2;
    src2_used[s]  = u2;
    dst_wen[s]    = w;
    dst_addr[s]   = d;
    exec_class[s] = c;
  endtask

  task automatic rd(input int s, input logic [4:0] a);
    slot(s, a, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0);
  endtask

  task automatic wr(input int s, input logic [4:0] d, input logic [2:0] c);
    slot(s, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, d, c);
  endtask

  task automatic wb(input int p, input logic [4:0] a);
    wb_valid[p] = 1'b1;
    wb_addr[p]  = a;
  endtask

  // Inputs are applied just after a rising edge; issue_fire is sampled on the falling edge.
  task automatic cyc(input string tag, input logic [1:0] exp_fire);
    @(negedge clk);
    check_eq(tag, 32'(issue_fire), 32'(exp_fire));
    if (in_valid[0] && !exp_fire[0] && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    resetn    = 1'b0;
    exp_stall = '0;
    rd(0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_fire", 32'(issue_fire), 32'd0);
    check_eq("reset_stall", stall_cycles, 32'd0);
    resetn = 1'b1;
    idle();

    // MUL producer then dependent reader; no warm-up after reset.
    wr(0, 5'd5, 3'd2);   cyc("mul_issue", 2'b01);
    rd(0, 5'd5);         cyc("mul_wait1", 2'b00);
    rd(0, 5'd5);         cyc("mul_wait2", 2'b00);
    rd(0, 5'd5);         cyc("mul_ready", 2'b01);
    check_eq("mul_stall_cnt", stall_cycles, 32'd2);

    // Intra-group RAW through src2, then retry as slot 0.
    wr(0, 5'd3, 3'd0);
    slot(1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 3'd0);
    cyc("raw01_block", 2'b01);
    slot(0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 3'd0);
    cyc("raw01_retry", 2'b01);

    wr(0, 5'd10, 3'd0);
    slot(1, 5'd11, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 3'd1);
    cyc("dual_issue", 2'b11);
    wr(0, 5'd13, 3'd0); wr(1, 5'd13, 3'd3);
    cyc("waw01_block", 2'b01);

    // DIV waits for writeback; unused source ignored; WAW on pending DIV blocked.
    wr(0, 5'd7, 3'd4);   cyc("div_issue", 2'b01);
    for (int k = 1; k < 18; k++) begin
      rd(0, 5'd7);       cyc("div_wait", 2'b00);
    end
    slot(0, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 3'd0);
    cyc("div_unused_src", 2'b01);
    wr(0, 5'd7, 3'd0);   cyc("div_waw_block", 2'b00);
    rd(0, 5'd7); wb(1, 5'd7);
    cyc("div_wb_bypass", 2'b01);
    rd(0, 5'd7);         cyc("div_cleared", 2'b01);
    check_eq("div_stall_cnt", stall_cycles, exp_stall);

    // Class 6 behaves as DIV; both wb ports naming the same register.
    wr(0, 5'd20, 3'd6);  cyc("cls6_issue", 2'b01);
    rd(0, 5'd20);        cyc("cls6_wait", 2'b00);
    rd(0, 5'd20); wb(0, 5'd20); wb(1, 5'd20);
    cyc("cls6_dual_wb", 2'b01);
    rd(0, 5'd20);        cyc("cls6_cleared", 2'b01);

    // Allocation wins over same-cycle writeback: MEM count restarts at 2.
    wr(0, 5'd9, 3'd3); wb(0, 5'd9);
    cyc("mem_alloc_wb", 2'b01);
    rd(0, 5'd9);         cyc("mem_wait", 2'b00);
    rd(0, 5'd9);         cyc("mem_ready", 2'b01);

    // stall_in and flush both suppress issue; flush clears pending DIV.
    wr(0, 5'd4, 3'd4);   cyc("flush_div_issue", 2'b01);
    rd(0, 5'd4);         cyc("flush_div_wait", 2'b00);
    rd(0, 5'd1); stall_in = 1'b1;
    cyc("stall_in_block", 2'b00);
    rd(0, 5'd1); flush = 1'b1;
    cyc("flush_block", 2'b00);
    rd(0, 5'd4);         cyc("post_flush", 2'b01);
    check_eq("flush_stall_cnt", stall_cycles, exp_stall);

    // r0 traffic never touches state: repeated DIV writes to r0 never block.
    slot(0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 3'd4);
    slot(1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 3'd4);
    cyc("r0_first", 2'b11);
    slot(0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 3'd4);
    slot(1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 3'd7);
    cyc("r0_second", 2'b11);

    // Asynchronous reset during a DIV stall.
    wr(0, 5'd8, 3'd4);   cyc("rst_div_issue", 2'b01);
    rd(0, 5'd8);         cyc("rst_div_wait", 2'b00);
    check_eq("pre_rst_stall", stall_cycles, exp_stall);
    rd(0, 5'd8);
    resetn = 1'b0;
    #1;
    check_eq("rst_async_fire", 32'(issue_fire), 32'd0);
    check_eq("rst_async_stall", stall_cycles, 32'd0);
    idle();
    rd(0, 5'd0);
    #1;
    check_eq("rst_gate_fire", 32'(issue_fire), 32'd0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    exp_stall = '0;
    idle();
    rd(0, 5'd8);         cyc("post_rst_ready", 2'b01);
    check_eq("post_rst_stall", stall_cycles, exp_stall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
